// File: rtl/matrix_lfsr_stream.sv
// GF(2) matrix-step sequence generator with a runtime-loadable matrix and seed.
// Emits one state word per accepted transfer on a valid/ready stream, with run-length and lock-up handling.
module matrix_lfsr_stream #(
    parameter int WIDTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             row_we,
    input  logic [AW-1:0]    row_addr,
    input  logic [WIDTH-1:0] row_data,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] run_len,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             wr_err,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [WIDTH-1:0] r_rows [WIDTH];
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_lockup;
    logic             r_done;
    logic             r_wr_err;
    logic             w_idle;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_len_end;
    logic             w_zero_end;
    logic             w_row_ok;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_state[i]) w_next = w_next ^ r_rows[i];
        end
    end

    assign w_idle     = (r_fsm != S_RUN);
    assign w_start_ok = start && !abort && w_idle;
    assign w_xfer     = (r_fsm == S_RUN) && out_ready && !abort;
    assign w_cnt_inc  = r_word_cnt + 1'b1;
    assign w_len_end  = (run_len != '0) && (w_cnt_inc == run_len);
    // The only way to hold a zero state in RUN is the word emitted after a lock-up.
    assign w_zero_end = (r_state == '0);
    assign w_row_ok   = row_we && w_idle && ({1'b0, row_addr} < (AW+1)'(WIDTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        if (abort) begin
            w_fsm_nxt = S_IDLE;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (start) w_fsm_nxt = (seed != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (w_xfer && (w_len_end || w_zero_end)) w_fsm_nxt = S_DONE;
                end
                default: w_fsm_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: the row memory is reset because a mid-run reset must restore the identity matrix.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= '0;
            r_word_cnt <= '0;
            r_lockup   <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) r_rows[i] <= WIDTH'(1) << i;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= row_we && (r_fsm == S_RUN);
            if (w_start_ok) begin
                r_state    <= seed;
                r_word_cnt <= '0;
                r_lockup   <= (seed == '0);
                r_done     <= (seed == '0);
            end else if (w_xfer) begin
                r_state    <= w_next;
                r_word_cnt <= w_cnt_inc;
                if (w_next == '0)            r_lockup <= 1'b1;
                if (w_len_end || w_zero_end) r_done   <= 1'b1;
            end
            if (w_row_ok) r_rows[row_addr] <= row_data;
        end
    end

    assign out_data  = r_state;
    assign busy      = (r_fsm == S_RUN);
    assign out_valid = busy;
    assign done      = r_done;
    assign lockup    = r_lockup;
    assign wr_err    = r_wr_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_matrix_lfsr_stream.sv
// Scoreboard bench for matrix_lfsr_stream: directed cases plus randomized matrices, seeds and handshakes.
// Expected words come from a column-parity GF(2) model; a negedge monitor pops and compares transfers.
module tb_matrix_lfsr_stream;

    localparam int W  = 8;
    localparam int AW = 3;
    localparam int CW = 16;

    logic          clock     = 1'b0;
    logic          reset_b   = 1'b0;
    logic          row_we    = 1'b0;
    logic [AW-1:0] row_addr  = '0;
    logic [W-1:0]  row_data  = '0;
    logic [W-1:0]  seed      = '0;
    logic [CW-1:0] run_len   = '0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          lockup;
    logic          wr_err;
    logic [CW-1:0] word_cnt;

    matrix_lfsr_stream #(.WIDTH(W), .AW(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset_b(reset_b), .row_we(row_we), .row_addr(row_addr),
        .row_data(row_data), .seed(seed), .run_len(run_len), .start(start),
        .abort(abort), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .lockup(lockup),
        .wr_err(wr_err), .word_cnt(word_cnt)
    );

    always #5 clock = ~clock;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_xfer = 0;
    int           n_done = 0;
    int           ready_mode = 0;
    bit           ready_phase = 1'b1;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_rows[W];
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Output bit j is the parity of the state masked by column j of the matrix.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic [W-1:0] col;
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < W; i++) col[i] = m_rows[i][j];
            r[j] = ^(s & col);
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset_b) begin
            if (prev_stall && out_valid) check("hold_stable", out_data, prev_data);
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_word: got %0h required no word", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
                n_xfer++;
            end
            if (done) n_done++;
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = ready_phase; ready_phase = !ready_phase; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic load_row(input int a, input logic [W-1:0] d);
        row_addr = AW'(a);
        row_data = d;
        row_we   = 1'b1;
        step();
        row_we   = 1'b0;
        m_rows[a] = d;
    endtask

    task automatic load_identity();
        for (int i = 0; i < W; i++) load_row(i, W'(1) << i);
    endtask

    // One complete run: build the expected word list, start, wait, then check the ending.
    task automatic run(input logic [W-1:0] sd, input logic [CW-1:0] rl,
                       input int abort_after, input int wr_at);
        logic [W-1:0] w;
        logic [W-1:0] nxt;
        int           n = 0;
        bit           lock = 1'b0;
        bit           fin = 1'b0;
        int           budget = 0;
        int           d0;
        if (sd == '0) begin
            lock = 1'b1;
            fin  = 1'b1;
        end else begin
            w = sd;
            while (!fin && !(abort_after > 0 && n >= abort_after) && n < 200) begin
                exp_q.push_back(w);
                n++;
                nxt = mstep(w);
                if (nxt == '0) lock = 1'b1;
                if ((rl != '0 && n == int'(rl)) || w == '0) fin = 1'b1;
                w = nxt;
            end
        end
        d0      = n_done;
        n_xfer  = 0;
        seed    = sd;
        run_len = rl;
        start   = 1'b1;
        step();
        start   = 1'b0;
        if (sd != '0) begin
            while (n_xfer < n && budget < 2000) begin
                if (budget == wr_at) begin
                    row_addr = AW'($urandom);
                    row_data = W'($urandom);
                    row_we   = 1'b1;
                    step();
                    row_we   = 1'b0;
                    check("wr_err_pulse", wr_err, 1);
                end else begin
                    step();
                end
                budget++;
            end
            if (n_xfer < n) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got %0d words required %0d", n_xfer, n);
            end
            if (!fin) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_state_held", out_data, w);
            end
        end
        check("done_now", done, fin);
        step();
        check("done_count", n_done - d0, fin);
        check("done_pulse_low", done, 0);
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
        check("word_cnt", word_cnt, n);
        check("lockup", lockup, lock);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] crc [W];
        for (int i = 0; i < W; i++) m_rows[i] = W'(1) << i;
        for (int i = 0; i < W-1; i++) crc[i] = W'(1) << (i + 1);
        crc[W-1] = 8'h07;

        #3;
        check("reset_outputs", {out_data, out_valid, busy, done, lockup, wr_err, word_cnt}, 0);
        #10;
        reset_b = 1'b1;
        step();

        run(8'h5A, 16'd3, 0, -1);

        for (int i = 0; i < W; i++) load_row(i, crc[i]);
        run(8'h01, 16'd10, 0, -1);

        ready_mode  = 1;
        ready_phase = 1'b1;
        run(8'h01, 16'd10, 0, -1);

        ready_mode = 0;
        run(8'h01, 16'd0, 6, 2);

        load_identity();
        load_row(0, 8'h00);
        run(8'h01, 16'd0, 0, -1);
        run(8'h01, 16'd1, 0, -1);
        run(8'h00, 16'd5, 0, -1);

        ready_mode = 3;
        seed       = 8'h33;
        run_len    = 16'd0;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
        check("pre_reset_busy", busy, 1);
        reset_b = 1'b0;
        #2;
        check("async_reset_outputs", {out_data, out_valid, busy, done, lockup, wr_err, word_cnt}, 0);
        for (int i = 0; i < W; i++) m_rows[i] = W'(1) << i;
        #4;
        reset_b    = 1'b1;
        ready_mode = 0;
        step();
        run(8'h5A, 16'd3, 0, -1);

        for (int t = 0; t < 25; t++) begin
            logic [W-1:0] sd;
            logic [CW-1:0] rl;
            int ab;
            for (int i = 0; i < W; i++)
                load_row(i, ($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom));
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            rl = CW'($urandom_range(0, 20));
            if (rl == '0)                        ab = $urandom_range(1, 30);
            else if ($urandom_range(0, 3) == 0)  ab = $urandom_range(1, 20);
            else                                 ab = 0;
            ready_mode = $urandom_range(0, 2);
            run(sd, rl, ab, ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
